scoreboard_hazard_unit: RTL and testbench
=========================================

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width (4 for RV32E).
REQ-002 SHALL have parameter MD_LAT, default 4, meaning mul/div occupancy of stage E in cycles; legal values are 1 to 64.
REQ-003 SHALL have parameter CNT_W, default 16, meaning performance-counter width.
REQ-004 SHALL expose the following ports, one per line (name, direction, width, meaning):
  clk  in  1  clock; the only clock.
  rst  in  1  synchronous, active-high reset.
  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_AW  stage register addresses.
  UseRs1D, UseRs2D  in  1  decode instruction actually reads the source.
  RegWriteM, RegWriteW  in  1  destination-write enables.
  ResultSrcE, ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate.
  PCSrcE  in  2  00 sequential, 01 branch/jal taken, 10 jalr.
  MdE  in  1  stage E holds a mul/div instruction.
  CntClr  in  1  clears the performance counters.
  StallF, StallD, StallE  out  1  hold the stage register.
  FlushD, FlushE, FlushM  out  1  bubble the stage register.
  ForwardAE, ForwardBE  out  2  operand mux select.
  MdBusy  out  1  the mul/div FSM is not IDLE.
  StallCnt, FlushCnt  out  CNT_W  performance counters.

Function
REQ-005 SHALL set ForwardAE as follows, in priority order (ForwardBE identical, using Rs2E):
  - 11 when Rs1E==RdM, RegWriteM=1 and ResultSrcM=11;
  - else 10 when Rs1E==RdM and RegWriteM=1;
  - else 01 when Rs1E==RdW and RegWriteW=1;
  - else 00.
  - Any source address equal to 0 SHALL yield 00.
REQ-006 SHALL assert lwStall when ResultSrcE=01, RdE!=0, and either (UseRs1D=1 and Rs1D==RdE) or (UseRs2D=1 and Rs2D==RdE).
REQ-007 SHALL implement FSM states IDLE and BUSY, with a down-counter cnt of width clog2(MD_LAT).
REQ-008 In IDLE with MdE=1 and MD_LAT>1, SHALL assert hold and move next to BUSY with cnt=MD_LAT-2.
REQ-009 In BUSY with cnt!=0, SHALL assert hold and decrement cnt; in BUSY with cnt==0, SHALL deassert hold and move next to IDLE.
REQ-010 With MD_LAT=1, SHALL never leave IDLE and never assert hold; the mul/div instruction occupies E for exactly MD_LAT cycles.
REQ-011 hold SHALL drive StallF=StallD=StallE=1 and FlushM=1; MdBusy SHALL equal (state==BUSY).
REQ-012 Without hold, SHALL drive StallF=StallD=lwStall and FlushE = lwStall OR (PCSrcE!=00).
REQ-013 Without hold, SHALL drive FlushD = (PCSrcE!=00), covering both 01 and 10.
REQ-014 Under hold, SHALL force lwStall, FlushD and FlushE to 0; hold dominates all other causes.
REQ-015 Forwarding SHALL stay combinational and active during hold.
REQ-016 StallCnt SHALL increment on each cycle with StallF=1, saturating at all-ones.
REQ-017 FlushCnt SHALL increment on each cycle with FlushE=1 and PCSrcE!=00, saturating at all-ones.
REQ-018 CntClr=1 SHALL zero both counters on the next edge and SHALL take priority over increment.
REQ-019 All outputs other than the counters and MdBusy SHALL be combinational from the inputs and FSM state; there is no added latency.

Reset
REQ-020 rst=1 at a clock edge SHALL set state to IDLE, cnt=0, StallCnt=0 and FlushCnt=0.
REQ-021 rst asserted mid-BUSY SHALL abort the occupancy; hold SHALL drop in the first cycle after reset unless MdE=1 restarts it.

Structure
REQ-022 Package hazard_pkg SHALL hold the Forward, ResultSrc and PCSrc encodings and the FSM state enum.
REQ-023 The FSM and cnt SHALL live in sub-module md_occupancy_ctr (ports clk, rst, MdE, hold, busy); forwarding and counters stay in the top level.

Verification
REQ-024 Forwarding: Rs1E=5, RdM=5, RegWriteM=1, ResultSrcM=11, RdW=5, RegWriteW=1 -> ForwardAE=11; with ResultSrcM=00 -> 10; with RegWriteM=0 -> 01; with Rs1E=0 -> 00.
REQ-025 Load-use: ResultSrcE=01, RdE=7, Rs2D=7, UseRs2D=1 -> StallF=StallD=FlushE=1; with UseRs2D=0 -> all 0.
REQ-026 Mul/div with MD_LAT=4: MdE=1 held -> hold=1 for exactly 3 cycles, StallE=FlushM=1 throughout, 0 on the 4th cycle, then IDLE; repeat with MD_LAT=1 -> hold never asserted.
REQ-027 Priority: during BUSY, force PCSrcE=01 and lwStall conditions -> FlushD=FlushE=0; FlushCnt unchanged.
REQ-028 Counters: 70000 stall cycles with CNT_W=16 -> StallCnt=FFFF; CntClr=1 together with a stall -> 0 next cycle.
REQ-029 Reset: rst pulsed in the second BUSY cycle -> state=IDLE, counters 0; with MdE=0 afterwards -> no hold.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: operand-forward selects, result
// sources, PC redirect sources and the mul/div occupancy FSM state.
package hazard_pkg;

    // Operand forward mux selects
    localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
    localparam logic [1:0] FWD_WB   = 2'b01;  // writeback stage result
    localparam logic [1:0] FWD_MEM  = 2'b10;  // memory stage ALU result
    localparam logic [1:0] FWD_IMM  = 2'b11;  // memory stage immediate

    // Result source encodings
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_IMM  = 2'b11;

    // PC source encodings
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    // Mul/div occupancy FSM states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Forward-select priority: the youngest producer (memory) wins over
    // writeback, and a memory-stage immediate is selected on its own leg.
    function automatic logic [1:0] fwd_prio(input logic hit_m,
                                            input logic hit_w,
                                            input logic imm_m);
        logic [1:0] sel;
        if (hit_m && imm_m) begin
            sel = FWD_IMM;
        end else if (hit_m) begin
            sel = FWD_MEM;
        end else if (hit_w) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/md_occupancy_ctr.sv
// Mul/div occupancy tracker: holds the pipeline so that a mul/div
// instruction stays in the execute stage for exactly MD_LAT cycles.
module md_occupancy_ctr
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic MdE,
    output logic hold,
    output logic busy
);

    // A single-cycle unit never needs a counter; keep one bit so the
    // register stays legal.
    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    // The IDLE cycle that accepts the instruction is the first of MD_LAT,
    // and the cnt==0 BUSY cycle is the last, so BUSY starts at MD_LAT-2.
    localparam logic [CW-1:0] CNT_START = (MD_LAT > 1) ? CW'(MD_LAT - 2) : '0;

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // State and down-counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and hold generation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
        case (state_q)
            IDLE: begin
                if (MdE && (MD_LAT > 1)) begin
                    hold    = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_START;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    hold  = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == BUSY);

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, control-flow
// flush, mul/div occupancy hold and saturating stall/flush counters.
module scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              UseRs1D,
    input  logic              UseRs2D,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic [1:0]        ResultSrcM,
    input  logic [1:0]        PCSrcE,
    input  logic              MdE,
    input  logic              CntClr,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MdBusy,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    logic             hold_s;
    logic             lw_stall_s;
    logic             redirect_s;
    logic             hit_ma_s, hit_wa_s, hit_mb_s, hit_wb_s, imm_m_s;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    md_occupancy_ctr #(
        .MD_LAT (MD_LAT)
    ) u_md_occ (
        .clk  (clk),
        .rst  (rst),
        .MdE  (MdE),
        .hold (hold_s),
        .busy (MdBusy)
    );

    // Forwarding matches; x0 never forwards. Stays live during hold so the
    // held mul/div keeps seeing current operands.
    always_comb begin
        imm_m_s   = (ResultSrcM == RES_IMM);
        hit_ma_s  = (Rs1E != '0) && (Rs1E == RdM) && RegWriteM;
        hit_wa_s  = (Rs1E != '0) && (Rs1E == RdW) && RegWriteW;
        hit_mb_s  = (Rs2E != '0) && (Rs2E == RdM) && RegWriteM;
        hit_wb_s  = (Rs2E != '0) && (Rs2E == RdW) && RegWriteW;
        ForwardAE = fwd_prio(hit_ma_s, hit_wa_s, imm_m_s);
        ForwardBE = fwd_prio(hit_mb_s, hit_wb_s, imm_m_s);
    end

    // Stall/flush control; the mul/div hold dominates every other cause
    // because the instruction in E cannot be bubbled or redirected.
    always_comb begin
        redirect_s = (PCSrcE != PC_SEQ);
        lw_stall_s = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        if (hold_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else begin
            lw_stall_s = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
                         ((UseRs1D && (Rs1D == RdE)) || (UseRs2D && (Rs2D == RdE)));
            StallF     = lw_stall_s;
            StallD     = lw_stall_s;
            FlushD     = redirect_s;
            FlushE     = lw_stall_s | redirect_s;
        end
    end

    // Counter next-state: clear beats increment, increments saturate
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CntClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (StallF && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (FlushE && redirect_s && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // Performance counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit: one instance with MD_LAT=4,
// one with MD_LAT=1, driven by the same inputs.
module tb_scoreboard_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 16;

    // Control vector order: StallF StallD StallE FlushD FlushE FlushM
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LW   = 6'b110010;
    localparam logic [5:0] C_BR   = 6'b000110;
    localparam logic [5:0] C_LWBR = 6'b110110;
    localparam logic [5:0] C_HOLD = 6'b111001;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          UseRs1D, UseRs2D, RegWriteM, RegWriteW, MdE, CntClr;
    logic [1:0]    ResultSrcE, ResultSrcM, PCSrcE;

    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] StallCnt, FlushCnt;

    logic          StallF_b, StallD_b, StallE_b, FlushD_b, FlushE_b, FlushM_b, MdBusy_b;
    logic [1:0]    ForwardAE_b, ForwardBE_b;
    logic [CW-1:0] StallCnt_b, FlushCnt_b;

    int            n_pass  = 0;
    int            n_total = 0;
    int            n_fail  = 0;
    string         tag_q[$];
    logic [31:0]   exp_q[$];

    always #5 clk = ~clk;

    scoreboard_hazard_unit #(.REG_AW(AW), .MD_LAT(4), .CNT_W(CW)) u_dut4 (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .PCSrcE(PCSrcE),
        .MdE(MdE), .CntClr(CntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MdBusy(MdBusy),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    scoreboard_hazard_unit #(.REG_AW(AW), .MD_LAT(1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .PCSrcE(PCSrcE),
        .MdE(MdE), .CntClr(CntClr),
        .StallF(StallF_b), .StallD(StallD_b), .StallE(StallE_b),
        .FlushD(FlushD_b), .FlushE(FlushE_b), .FlushM(FlushM_b),
        .ForwardAE(ForwardAE_b), .ForwardBE(ForwardBE_b), .MdBusy(MdBusy_b),
        .StallCnt(StallCnt_b), .FlushCnt(FlushCnt_b)
    );

    // Push an expected value into the scoreboard
    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with the observed value
    task automatic compare(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_total++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: got %0h expected <entry>", obs);
        end
        if (exp_q.size() != 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: got %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] e, input logic [31:0] obs);
        expect_v(tag, e);
        compare(obs);
    endtask

    task automatic chk_ctl(input string tag, input logic [5:0] e);
        chk(tag, 32'(e), 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM}));
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        UseRs1D = 1'b0; UseRs2D = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; ResultSrcM = 2'b00; PCSrcE = 2'b00;
        MdE = 1'b0; CntClr = 1'b0;
    endtask

    task automatic set_load_use();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; UseRs1D = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stallcnt", 32'h0, 32'(StallCnt));
        chk("rst_flushcnt", 32'h0, 32'(FlushCnt));
        chk("rst_mdbusy",   32'h0, 32'(MdBusy));
        chk("rst_mdbusy_b", 32'h0, 32'(MdBusy_b));
        chk_ctl("rst_ctl", C_NONE);

        // Forwarding priority
        @(negedge clk);
        Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; ResultSrcM = 2'b11;
        RdW = 5'd5; RegWriteW = 1'b1;
        #1;
        chk("fwdA_imm", 32'h3, 32'(ForwardAE));
        chk("fwdB_imm", 32'h3, 32'(ForwardBE));
        @(negedge clk);
        ResultSrcM = 2'b00;
        #1;
        chk("fwdA_mem", 32'h2, 32'(ForwardAE));
        chk("fwdB_mem", 32'h2, 32'(ForwardBE));
        @(negedge clk);
        RegWriteM = 1'b0;
        #1;
        chk("fwdA_wb", 32'h1, 32'(ForwardAE));
        @(negedge clk);
        Rs1E = 5'd0;
        #1;
        chk("fwdA_x0", 32'h0, 32'(ForwardAE));
        chk("fwdB_wb", 32'h1, 32'(ForwardBE));
        @(negedge clk);
        Rs1E = 5'd9; RdM = 5'd3; RegWriteM = 1'b1; ResultSrcM = 2'b11; RdW = 5'd9;
        #1;
        chk("fwdA_wb_only", 32'h1, 32'(ForwardAE));
        @(negedge clk);
        Rs1E = 5'd0; Rs2E = 5'd0; RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        chk("fwdA_all_x0", 32'h0, 32'(ForwardAE));
        chk("fwdB_all_x0", 32'h0, 32'(ForwardBE));

        // Load-use stall
        @(negedge clk);
        clear_inputs();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; UseRs2D = 1'b1;
        #1;
        chk_ctl("lw_rs2", C_LW);
        @(negedge clk);
        UseRs2D = 1'b0;
        #1;
        chk_ctl("lw_rs2_unused", C_NONE);
        chk("lw_stallcnt1", 32'd1, 32'(StallCnt));
        chk("lw_flushcnt0", 32'd0, 32'(FlushCnt));
        @(negedge clk);
        Rs1D = 5'd7; UseRs1D = 1'b1;
        #1;
        chk_ctl("lw_rs1", C_LW);
        @(negedge clk);
        RdE = 5'd0; Rs1D = 5'd0;
        #1;
        chk_ctl("lw_rd_x0", C_NONE);

        // Control-flow flush
        @(negedge clk);
        clear_inputs();
        PCSrcE = 2'b01;
        #1;
        chk_ctl("br_taken", C_BR);
        @(negedge clk);
        PCSrcE = 2'b10;
        #1;
        chk_ctl("br_jalr", C_BR);
        chk("br_flushcnt1", 32'd1, 32'(FlushCnt));
        @(negedge clk);
        set_load_use();
        #1;
        chk_ctl("br_plus_lw", C_LWBR);
        chk("br_flushcnt2", 32'd2, 32'(FlushCnt));
        @(negedge clk);
        clear_inputs();
        #1;
        chk_ctl("br_idle", C_NONE);
        chk("br_stallcnt3", 32'd3, 32'(StallCnt));
        chk("br_flushcnt3", 32'd3, 32'(FlushCnt));

        // Mul/div occupancy, MD_LAT=4 versus MD_LAT=1
        @(negedge clk);
        MdE = 1'b1;
        #1;
        chk_ctl("md_c1", C_HOLD);
        chk("md_c1_busy", 32'd0, 32'(MdBusy));
        chk("md1_c1_stalle", 32'd0, 32'(StallE_b));
        @(negedge clk);
        PCSrcE = 2'b01; set_load_use();
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; ResultSrcM = 2'b00;
        #1;
        chk_ctl("md_c2_prio", C_HOLD);
        chk("md_c2_busy", 32'd1, 32'(MdBusy));
        chk("md_c2_fwd", 32'h2, 32'(ForwardAE));
        chk("md1_c2_stalle", 32'd0, 32'(StallE_b));
        chk("md1_c2_busy", 32'd0, 32'(MdBusy_b));
        @(negedge clk);
        clear_inputs();
        MdE = 1'b1;
        #1;
        chk_ctl("md_c3", C_HOLD);
        chk("md_c3_flushcnt", 32'd3, 32'(FlushCnt));
        chk("md1_c3_stalle", 32'd0, 32'(StallE_b));
        @(negedge clk);
        #1;
        chk_ctl("md_c4_release", C_NONE);
        chk("md_c4_busy", 32'd1, 32'(MdBusy));
        @(negedge clk);
        MdE = 1'b0;
        #1;
        chk_ctl("md_c5_idle", C_NONE);
        chk("md_c5_busy", 32'd0, 32'(MdBusy));
        chk("md_c5_stallcnt", 32'd6, 32'(StallCnt));

        // Reset in the middle of an occupancy
        @(negedge clk);
        MdE = 1'b1;
        #1;
        chk_ctl("rb_c1", C_HOLD);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rb_c2_busy", 32'd1, 32'(MdBusy));
        chk("rb_c2_stallcnt", 32'd7, 32'(StallCnt));
        @(negedge clk);
        rst = 1'b0; MdE = 1'b0;
        #1;
        chk_ctl("rb_after", C_NONE);
        chk("rb_after_busy", 32'd0, 32'(MdBusy));
        chk("rb_after_stallcnt", 32'd0, 32'(StallCnt));
        chk("rb_after_flushcnt", 32'd0, 32'(FlushCnt));

        // Counter saturation and clear priority
        @(negedge clk);
        set_load_use();
        repeat (70000) @(negedge clk);
        #1;
        chk("sat_stallcnt", 32'hFFFF, 32'(StallCnt));
        chk("sat_flushcnt", 32'h0, 32'(FlushCnt));
        CntClr = 1'b1;
        @(negedge clk);
        CntClr = 1'b0;
        #1;
        chk("clr_stallcnt", 32'h0, 32'(StallCnt));
        @(negedge clk);
        #1;
        chk("clr_then_inc", 32'h1, 32'(StallCnt));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
